// File: rtl/uart_pkg.sv
// Shared UART parity definitions: mode codes, RX state encoding and the
// parity rule used by both the TX and RX paths.
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'b00,
        RX_DATA   = 2'b01,
        RX_PARITY = 2'b10
    } rx_state_e;

    typedef struct packed {
        logic       en;
        logic [1:0] mode;
    } rx_cfg_t;

    function automatic logic parity_bit(input logic xor_in, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN:  p = xor_in;
            PAR_ODD:   p = ~xor_in;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_engine_if.sv
// Bundle of configuration, TX and RX parity signals between the UART FSMs
// and the parity engine.
interface parity_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cfg_en;
    logic [1:0]            cfg_mode;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_parity;
    logic                  rx_start;
    logic                  rx_bit_valid;
    logic                  rx_bit;
    logic                  rx_done;
    logic                  rx_par_err;

    modport master (
        output cfg_en, cfg_mode, tx_load, tx_data, rx_start, rx_bit_valid, rx_bit,
        input  tx_parity, rx_done, rx_par_err
    );

    modport slave (
        input  cfg_en, cfg_mode, tx_load, tx_data, rx_start, rx_bit_valid, rx_bit,
        output tx_parity, rx_done, rx_par_err
    );
endinterface

// File: rtl/parity_rx_checker.sv
// Serial RX parity checker: accumulates data bits LSB-first and compares the
// trailing parity bit against the configuration latched at frame start.
module parity_rx_checker
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_en,
    input  logic [1:0] cfg_mode,
    input  logic       rx_start,
    input  logic       rx_bit_valid,
    input  logic       rx_bit,
    output logic       rx_done,
    output logic       rx_par_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    rx_cfg_t          rx_cfg_r;
    logic             acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rx_done_r;
    logic             rx_par_err_r;
    logic             done_s;
    logic             err_s;
    logic             last_data_s;

    assign last_data_s = rx_bit_valid && (cnt_r == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; rx_start restarts the frame from any state
    always_comb begin
        state_nxt_s = state_r;
        if (rx_start) begin
            state_nxt_s = RX_DATA;
        end else begin
            case (state_r)
                RX_IDLE:   state_nxt_s = RX_IDLE;
                RX_DATA: begin
                    if (last_data_s) begin
                        state_nxt_s = rx_cfg_r.en ? RX_PARITY : RX_IDLE;
                    end else begin
                        state_nxt_s = RX_DATA;
                    end
                end
                RX_PARITY: state_nxt_s = rx_bit_valid ? RX_IDLE : RX_PARITY;
                default:   state_nxt_s = RX_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered done pulse and error flag
    always_comb begin
        done_s = 1'b0;
        err_s  = rx_par_err_r;
        if (rx_start) begin
            done_s = 1'b0;
            err_s  = rx_par_err_r;
        end else begin
            case (state_r)
                RX_DATA: begin
                    if (last_data_s && !rx_cfg_r.en) begin
                        done_s = 1'b1;
                        err_s  = 1'b0;
                    end else begin
                        done_s = 1'b0;
                        err_s  = rx_par_err_r;
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_valid) begin
                        done_s = 1'b1;
                        err_s  = rx_bit ^ parity_bit(acc_r, rx_cfg_r.mode);
                    end else begin
                        done_s = 1'b0;
                        err_s  = rx_par_err_r;
                    end
                end
                default: begin
                    done_s = 1'b0;
                    err_s  = rx_par_err_r;
                end
            endcase
        end
    end

    // Accumulator, bit counter, latched frame config and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= 1'b0;
            cnt_r        <= '0;
            rx_cfg_r     <= '0;
            rx_done_r    <= 1'b0;
            rx_par_err_r <= 1'b0;
        end else begin
            rx_done_r    <= done_s;
            rx_par_err_r <= err_s;
            if (rx_start) begin
                acc_r         <= 1'b0;
                cnt_r         <= '0;
                rx_cfg_r.en   <= cfg_en;
                rx_cfg_r.mode <= cfg_mode;
            end else if ((state_r == RX_DATA) && rx_bit_valid) begin
                acc_r <= acc_r ^ rx_bit;
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

    assign rx_done    = rx_done_r;
    assign rx_par_err = rx_par_err_r;

endmodule

// File: rtl/parity_engine.sv
// UART parity engine: TX parity generation for a configurable word width and
// an RX serial parity checker, sharing one parity rule.
module parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    parity_engine_if.slave  bus
);

    logic tx_xor_r;
    logic tx_parity_s;
    logic rx_done_s;
    logic rx_par_err_s;

    // Reduced XOR of the last loaded TX word
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_xor_r <= 1'b0;
        end else if (bus.tx_load) begin
            tx_xor_r <= ^bus.tx_data;
        end else begin
            tx_xor_r <= tx_xor_r;
        end
    end

    // Live mode applied to the stored XOR so mode changes show without reload
    always_comb begin
        tx_parity_s = 1'b0;
        if (bus.cfg_en) begin
            tx_parity_s = parity_bit(tx_xor_r, bus.cfg_mode);
        end else begin
            tx_parity_s = 1'b0;
        end
    end

    assign bus.tx_parity = tx_parity_s;

    parity_rx_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .cfg_en       (bus.cfg_en),
        .cfg_mode     (bus.cfg_mode),
        .rx_start     (bus.rx_start),
        .rx_bit_valid (bus.rx_bit_valid),
        .rx_bit       (bus.rx_bit),
        .rx_done      (rx_done_s),
        .rx_par_err   (rx_par_err_s)
    );

    assign bus.rx_done    = rx_done_s;
    assign bus.rx_par_err = rx_par_err_s;

endmodule

// File: doc/parity_engine.md
# parity_engine

Parametrised UART parity unit, successor to the fixed 8-bit TX parity calculator. Generates the parity bit for a configurable-width TX data word. Adds a serial RX parity checker that accumulates received data bits and flags a parity error at end of frame. Supports four parity modes. Sits between the UART TX serializer / RX deserializer FSMs and the register-file configuration fields.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_en  in  1  parity enable; 0 = no parity bit in frame
- cfg_mode  in  2  00 even, 01 odd, 10 mark (constant 1), 11 space (constant 0)
- tx_load  in  1  single-cycle strobe; latches tx_data
- tx_data  in  DATA_WIDTH  word to be transmitted
- tx_parity  out  1  parity bit for the last loaded word
- rx_start  in  1  single-cycle strobe; start of a new RX frame, clears the accumulator
- rx_bit_valid  in  1  qualifies rx_bit; data bits LSB-first, then the parity bit
- rx_bit  in  1  received serial bit
- rx_done  out  1  one-cycle pulse at end of frame
- rx_par_err  out  1  parity mismatch for the last completed frame

## Operation
- TX path: tx_load registers tx_xor = ^tx_data.
  - tx_parity is combinational from tx_xor and live cfg_mode: even → tx_xor; odd → ~tx_xor; mark → 1; space → 0.
  - cfg_en=0 forces tx_parity=0.
  - A cfg_mode change is reflected without a new load.
- RX FSM states: IDLE, DATA, PARITY.
  - IDLE: rx_bit_valid is ignored. On rx_start: clear acc and bit counter, latch cfg_en/cfg_mode into rx_cfg, go to DATA.
  - DATA: each rx_bit_valid XORs rx_bit into acc and increments cnt (width $clog2(DATA_WIDTH+1)).
  - DATA exit, on the valid that makes cnt reach DATA_WIDTH:
    - rx_cfg.en=1: go to PARITY.
    - rx_cfg.en=0: pulse rx_done with rx_par_err=0, go to IDLE.
  - PARITY: on rx_bit_valid, compute the expected bit from acc and rx_cfg.mode (same rule as TX). Set rx_par_err = (rx_bit != expected), pulse rx_done, go to IDLE.
- rx_start in DATA or PARITY aborts the frame and restarts it (same actions as from IDLE). No rx_done is issued for the aborted frame.
- rx_start and rx_bit_valid in the same cycle: rx_start wins and that bit is discarded.
- rx_par_err holds its value until the next completed frame or reset.
- TX and RX paths are fully independent and may be active in the same cycle.
- cfg changes mid-RX-frame do not affect that frame.

## Timing
- Reset values: tx_xor=0, so tx_parity=0 for even/space, 1 for odd/mark, 0 if cfg_en=0. rx_done=0, rx_par_err=0, FSM=IDLE, acc=0, cnt=0.
- tx_load sampled at edge k → new tx_parity valid after edge k, i.e. usable in cycle k+1. One-cycle latency.
- Final RX bit (parity bit, or last data bit when parity is disabled) sampled at edge n → rx_done high for exactly cycle n+1. rx_par_err is valid from the same edge.
- rst asserted mid-frame → IDLE at the next edge, no rx_done. rx_par_err is cleared.
- Back-to-back frames: rx_start is accepted in the same cycle rx_done is high.

## Structure
- Shared package uart_pkg:
  - parity mode constants PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11
  - RX FSM state encoding
  - function parity_bit(xor_in, mode) used by both paths
- One sub-module: parity_rx_checker (RX FSM, counter, accumulator).
- The TX path stays inline in parity_engine.

## Test plan
All scenarios use DATA_WIDTH=8.
- Load 8'hFF, even → tx_parity=0. Switch to odd without reload → tx_parity=1 next cycle.
- Load 8'hFE → even 1, odd 0, mark 1, space 0. cfg_en=0 → tx_parity=0 for every mode.
- RX, even mode, bits of 8'hA5 then parity 0 → rx_done one cycle after the parity bit, rx_par_err=0. Repeat with parity 1 → rx_par_err=1.
- RX with cfg_en=0: 8 bits of 8'h01 → rx_done one cycle after the 8th bit, rx_par_err=0. No parity bit is consumed.
- rx_start after 5 data bits, then a full frame of 8'h3C with odd parity bit 1 → exactly one rx_done, rx_par_err=0. Also: rx_bit_valid while IDLE has no effect.
- rst asserted after 4 bits → no rx_done, rx_par_err=0. Flip cfg_mode mid-frame → the result still uses the mode latched at rx_start.
